// File: rtl/reg_bus_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_bus_master_pkg
// Brief   : Shared types and command codes for the byte-stream register master
// Revision: 1.0 - initial release
// ============================================================================
package reg_bus_master_pkg;

  // Parser / bus sequencing states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    WDATA = 3'd3,
    WRITE = 3'd4,
    RWAIT = 3'd5,
    TX    = 3'd6
  } bus_master_state_e;

  localparam logic [7:0] CMD_READ  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;

endpackage
`default_nettype wire

// File: rtl/reg_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : reg_bus_master
// Brief   : Parses SYNC/CMD/ADDR[/D0..D3] byte packets into single register
//           bus reads/writes and streams read data back as 4 LE bytes.
// Revision: 1.0 - initial release
// ============================================================================
module reg_bus_master
  import reg_bus_master_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned TIMEOUT    = 5_000_000,
  parameter logic [7:0]  SYNC_BYTE  = 8'h55
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic [7:0]  ipRxData,
  input  logic        ipRxValid,
  output logic [7:0]  opTxData,
  output logic        opTxValid,
  input  logic        ipTxReady,
  output logic [7:0]  opAddress,
  output logic [31:0] opWrData,
  output logic        opWrEnable,
  input  logic [31:0] ipRdData,
  output logic        opError
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LW = $clog2(RD_LATENCY + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LAT_MAX = LW'(RD_LATENCY);

  bus_master_state_e state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          is_wr_q, is_wr_d;
  logic [7:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          err_q, err_d;

  logic w_timeout;
  assign w_timeout = (to_q == TO_MAX);

  // State and datapath registers; reset aborts any packet or transmission in flight
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      to_q     <= '0;
      lat_q    <= '0;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      lat_q    <= lat_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: packet parsing, inter-byte timeout, bus sequencing, TX handshake
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    to_d     = '0;
    lat_d    = '0;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    shadow_d = shadow_q;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ipRxValid && (ipRxData == SYNC_BYTE)) state_d = CMD;
      end

      CMD: begin
        // Expiry takes priority over a byte arriving in the same cycle
        if (w_timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (ipRxValid) begin
          if (ipRxData == CMD_READ) begin
            is_wr_d = 1'b0;
            state_d = ADDR;
          end else if (ipRxData == CMD_WRITE) begin
            is_wr_d = 1'b1;
            state_d = ADDR;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      ADDR: begin
        if (w_timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (ipRxValid) begin
          addr_d  = ipRxData;
          cnt_d   = '0;
          state_d = is_wr_q ? WDATA : RWAIT;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      WDATA: begin
        if (w_timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (ipRxValid) begin
          wdata_d[{cnt_q, 3'b000} +: 8] = ipRxData;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 2'd3) state_d = WRITE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      WRITE: begin
        err_d   = ipRxValid;
        state_d = IDLE;
      end

      RWAIT: begin
        err_d = ipRxValid;
        if (lat_q == LAT_MAX) begin
          shadow_d = ipRdData;
          cnt_d    = '0;
          state_d  = TX;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      TX: begin
        err_d = ipRxValid;
        if (ipTxReady) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 2'd3) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign opTxValid  = (state_q == TX);
  assign opTxData   = shadow_q[{cnt_q, 3'b000} +: 8];
  assign opWrEnable = (state_q == WRITE);
  assign opAddress  = addr_q;
  assign opWrData   = wdata_q;
  assign opError    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_bus_master
// Brief   : Directed self-checking bench for reg_bus_master
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_bus_master;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned TO     = 40;

  logic        ipClk = 1'b0;
  logic        ipReset = 1'b1;
  logic [7:0]  ipRxData = 8'h00;
  logic        ipRxValid = 1'b0;
  logic [7:0]  opTxData;
  logic        opTxValid;
  logic        ipTxReady = 1'b1;
  logic [7:0]  opAddress;
  logic [31:0] opWrData;
  logic        opWrEnable;
  logic [31:0] ipRdData = 32'h0;
  logic        opError;

  int total = 0;
  int bad   = 0;

  reg_bus_master #(.RD_LATENCY(RD_LAT), .TIMEOUT(TO), .SYNC_BYTE(8'h55)) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipRxData(ipRxData), .ipRxValid(ipRxValid),
    .opTxData(opTxData), .opTxValid(opTxValid), .ipTxReady(ipTxReady),
    .opAddress(opAddress), .opWrData(opWrData), .opWrEnable(opWrEnable),
    .ipRdData(ipRdData), .opError(opError)
  );

  always #5 ipClk = ~ipClk;

  // Observers sampled on the falling edge
  int          wr_cnt = 0;
  int          err_cnt = 0;
  int          stab_viol = 0;
  logic [7:0]  last_wr_addr;
  logic [31:0] last_wr_data;
  logic [7:0]  tx_q[$];
  logic        prev_stall = 1'b0;
  logic        prev_rst = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always @(negedge ipClk) begin
    if (opWrEnable) begin
      wr_cnt       = wr_cnt + 1;
      last_wr_addr = opAddress;
      last_wr_data = opWrData;
    end
    if (opError) err_cnt = err_cnt + 1;
    if (opTxValid && ipTxReady) tx_q.push_back(opTxData);
    if (prev_stall && !prev_rst && (!opTxValid || opTxData !== prev_data))
      stab_viol = stab_viol + 1;
    prev_stall = opTxValid && !ipTxReady;
    prev_data  = opTxData;
    prev_rst   = ipReset;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge ipClk); #1;
    ipRxData  = b;
    ipRxValid = 1'b1;
    @(posedge ipClk); #1;
    ipRxValid = 1'b0;
  endtask

  task automatic send_write(input logic [7:0] a, input logic [31:0] d);
    send_byte(8'h55); send_byte(8'h01); send_byte(a);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge ipClk);
    #1;
  endtask

  task automatic wait_txvalid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (opTxValid) begin ok = 1'b1; break; end
      @(posedge ipClk); #1;
    end
  endtask

  task automatic wait_tx_count(input int n);
    for (int i = 0; i < 200; i++) begin
      if (tx_q.size() >= n) break;
      @(posedge ipClk); #1;
    end
  endtask

  task automatic test_reset();
    ipReset = 1'b1;
    wait_cycles(3);
    total++; if (opTxValid !== 1'b0) begin bad++; $display("FAIL reset_txvalid got %b want 0", opTxValid); end
    total++; if (opWrEnable !== 1'b0) begin bad++; $display("FAIL reset_wren got %b want 0", opWrEnable); end
    total++; if (opError !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", opError); end
    total++; if (opAddress !== 8'h00) begin bad++; $display("FAIL reset_addr got %h want 00", opAddress); end
    total++; if (opWrData !== 32'h0) begin bad++; $display("FAIL reset_wrdata got %h want 00000000", opWrData); end
    ipReset = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_write();
    int wr0 = wr_cnt;
    int er0 = err_cnt;
    send_write(8'h02, 32'hDEADBEEF);
    // cycle after the edge accepting D3
    total++; if (opWrEnable !== 1'b1) begin bad++; $display("FAIL write_latency got %b want 1", opWrEnable); end
    total++; if (opAddress !== 8'h02) begin bad++; $display("FAIL write_addr got %h want 02", opAddress); end
    total++; if (opWrData !== 32'hDEADBEEF) begin bad++; $display("FAIL write_data got %h want deadbeef", opWrData); end
    wait_cycles(3);
    total++; if (wr_cnt - wr0 !== 1) begin bad++; $display("FAIL write_pulse_count got %0d want 1", wr_cnt - wr0); end
    total++; if (err_cnt - er0 !== 0) begin bad++; $display("FAIL write_err got %0d want 0", err_cnt - er0); end
  endtask

  task automatic test_read();
    int base = tx_q.size();
    logic [7:0] exp [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    ipTxReady = 1'b1;
    ipRdData  = 32'h12345678;
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h00);
    total++; if (opTxValid !== 1'b0) begin bad++; $display("FAIL read_early0 got %b want 0", opTxValid); end
    wait_cycles(RD_LAT);
    total++; if (opTxValid !== 1'b0) begin bad++; $display("FAIL read_early2 got %b want 0", opTxValid); end
    wait_cycles(1);
    total++; if (opTxValid !== 1'b1) begin bad++; $display("FAIL read_latency got %b want 1", opTxValid); end
    total++; if (opTxData !== 8'h78) begin bad++; $display("FAIL read_first_byte got %h want 78", opTxData); end
    ipRdData = 32'h0;
    wait_tx_count(base + 4);
    total++; if (tx_q.size() - base !== 4) begin bad++; $display("FAIL read_count got %0d want 4", tx_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (base + i < tx_q.size()) begin
        total++; if (tx_q[base + i] !== exp[i]) begin bad++; $display("FAIL read_byte%0d got %h want %h", i, tx_q[base + i], exp[i]); end
      end
    end
    wait_cycles(1);
    total++; if (opTxValid !== 1'b0) begin bad++; $display("FAIL read_done_valid got %b want 0", opTxValid); end
  endtask

  task automatic test_read_stall();
    int base = tx_q.size();
    int v0 = stab_viol;
    bit ok;
    logic [7:0] exp [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    ipTxReady = 1'b0;
    ipRdData  = 32'hA1B2C3D4;
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h10);
    wait_txvalid(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_valid_timeout got %b want 1", ok); end
    for (int k = 0; k < 4; k++) begin
      wait_cycles(10);
      ipTxReady = 1'b1;
      wait_cycles(1);
      ipTxReady = 1'b0;
    end
    wait_cycles(2);
    total++; if (tx_q.size() - base !== 4) begin bad++; $display("FAIL stall_count got %0d want 4", tx_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (base + i < tx_q.size()) begin
        total++; if (tx_q[base + i] !== exp[i]) begin bad++; $display("FAIL stall_byte%0d got %h want %h", i, tx_q[base + i], exp[i]); end
      end
    end
    total++; if (stab_viol - v0 !== 0) begin bad++; $display("FAIL stall_stability got %0d violations want 0", stab_viol - v0); end
    total++; if (opAddress !== 8'h10) begin bad++; $display("FAIL stall_addr got %h want 10", opAddress); end
    total++; if (opTxValid !== 1'b0) begin bad++; $display("FAIL stall_done_valid got %b want 0", opTxValid); end
    ipTxReady = 1'b1;
  endtask

  task automatic test_drop_busy();
    int base = tx_q.size();
    int er0 = err_cnt;
    bit ok;
    ipTxReady = 1'b0;
    ipRdData  = 32'h0BADF00D;
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h20);
    wait_txvalid(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL drop_valid_timeout got %b want 1", ok); end
    send_byte(8'h55);
    wait_cycles(2);
    total++; if (err_cnt - er0 !== 1) begin bad++; $display("FAIL drop_err got %0d want 1", err_cnt - er0); end
    total++; if (opTxValid !== 1'b1) begin bad++; $display("FAIL drop_state_valid got %b want 1", opTxValid); end
    total++; if (opTxData !== 8'h0D) begin bad++; $display("FAIL drop_state_data got %h want 0d", opTxData); end
    ipTxReady = 1'b1;
    wait_tx_count(base + 4);
    wait_cycles(1);
    total++; if (tx_q.size() - base !== 4) begin bad++; $display("FAIL drop_count got %0d want 4", tx_q.size() - base); end
  endtask

  task automatic test_bad_cmd();
    int wr0 = wr_cnt;
    int er0 = err_cnt;
    send_byte(8'h55); send_byte(8'h07);
    wait_cycles(2);
    total++; if (err_cnt - er0 !== 1) begin bad++; $display("FAIL badcmd_err got %0d want 1", err_cnt - er0); end
    send_write(8'h03, 32'h44332211);
    wait_cycles(2);
    total++; if (wr_cnt - wr0 !== 1) begin bad++; $display("FAIL badcmd_next_wr got %0d want 1", wr_cnt - wr0); end
    total++; if (last_wr_data !== 32'h44332211) begin bad++; $display("FAIL badcmd_next_data got %h want 44332211", last_wr_data); end
    total++; if (last_wr_addr !== 8'h03) begin bad++; $display("FAIL badcmd_next_addr got %h want 03", last_wr_addr); end
    total++; if (err_cnt - er0 !== 1) begin bad++; $display("FAIL badcmd_extra_err got %0d want 1", err_cnt - er0); end
  endtask

  task automatic test_timeout();
    int wr0 = wr_cnt;
    int er0 = err_cnt;
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h02); send_byte(8'hEF);
    wait_cycles(TO - 5);
    total++; if (err_cnt - er0 !== 0) begin bad++; $display("FAIL timeout_early got %0d want 0", err_cnt - er0); end
    wait_cycles(10);
    total++; if (err_cnt - er0 !== 1) begin bad++; $display("FAIL timeout_err got %0d want 1", err_cnt - er0); end
    total++; if (wr_cnt - wr0 !== 0) begin bad++; $display("FAIL timeout_no_write got %0d want 0", wr_cnt - wr0); end
    send_write(8'h05, 32'hCAFE0001);
    wait_cycles(2);
    total++; if (wr_cnt - wr0 !== 1) begin bad++; $display("FAIL timeout_next_wr got %0d want 1", wr_cnt - wr0); end
    total++; if (last_wr_data !== 32'hCAFE0001) begin bad++; $display("FAIL timeout_next_data got %h want cafe0001", last_wr_data); end
  endtask

  task automatic test_reset_mid_tx();
    int wr0;
    int er0;
    bit ok;
    ipTxReady = 1'b0;
    ipRdData  = 32'h87654321;
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h30);
    wait_txvalid(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rst_valid_timeout got %b want 1", ok); end
    ipTxReady = 1'b1;
    wait_cycles(1);
    ipTxReady = 1'b0;
    total++; if (opTxData !== 8'h43) begin bad++; $display("FAIL rst_second_byte got %h want 43", opTxData); end
    ipReset = 1'b1;
    wait_cycles(1);
    total++; if (opTxValid !== 1'b0) begin bad++; $display("FAIL rst_txvalid got %b want 0", opTxValid); end
    wait_cycles(1);
    ipReset = 1'b0;
    ipTxReady = 1'b1;
    wr0 = wr_cnt;
    er0 = err_cnt;
    send_byte(8'h12); send_byte(8'h34);
    send_write(8'h07, 32'h01020304);
    wait_cycles(2);
    total++; if (err_cnt - er0 !== 0) begin bad++; $display("FAIL rst_ignored_err got %0d want 0", err_cnt - er0); end
    total++; if (wr_cnt - wr0 !== 1) begin bad++; $display("FAIL rst_next_wr got %0d want 1", wr_cnt - wr0); end
    total++; if (last_wr_data !== 32'h01020304) begin bad++; $display("FAIL rst_next_data got %h want 01020304", last_wr_data); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_stall();
    test_drop_busy();
    test_bad_cmd();
    test_timeout();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
